// File: rtl/bayer_pattern_gen.sv
// Bayer BGGR test-pattern source: control packet, raster, blanking per frame.
// Ports: clk/rst, enable, pattern_sel, cfg_width/height, source_*, control_out_*, frame_done.
module bayer_pattern_gen #(
  parameter int W     = 1920,
  parameter int H     = 1080,
  parameter int BLANK = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] cfg_width,
  input  logic [15:0] cfg_height,
  output logic [7:0]  source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic [35:0] control_out_data,
  output logic        control_out_valid,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    S_IDLE, S_CTRL, S_ACTIVE, S_BLANK
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_x, w_x_nxt;
  logic [15:0] r_y, w_y_nxt;
  logic [15:0] r_w, w_w_nxt;
  logic [15:0] r_h, w_h_nxt;
  logic [1:0]  r_mode, w_mode_nxt;
  logic [7:0]  r_fcnt, w_fcnt_nxt;
  logic [15:0] r_bcnt, w_bcnt_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_cv, w_cv_nxt;
  logic [35:0] r_cdata, w_cdata_nxt;
  logic        r_done, w_done_nxt;
  logic        w_go;
  logic [15:0] w_eff_w, w_eff_h;
  logic [15:0] w_nx, w_ny;

  // Pixel value from the low byte of the coordinates; cube = {y[0],x[0]}.
  function automatic logic [7:0] f_pix(
    input logic [1:0] m,
    input logic [7:0] x,
    input logic [7:0] y,
    input logic [7:0] fc
  );
    logic [7:0] v;
    case (m)
      2'd0: begin
        case ({y[0], x[0]})
          2'b00:   v = 8'h40;
          2'b11:   v = 8'hC0;
          default: v = 8'h80;
        endcase
      end
      2'd1:    v = x;
      2'd2:    v = y;
      default: v = x + y + fc;
    endcase
    return v;
  endfunction

  assign w_eff_w = (cfg_width  == 16'd0) ? 16'(W) : cfg_width;
  assign w_eff_h = (cfg_height == 16'd0) ? 16'(H) : cfg_height;

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_w_nxt     = r_w;
    w_h_nxt     = r_h;
    w_mode_nxt  = r_mode;
    w_fcnt_nxt  = r_fcnt;
    w_bcnt_nxt  = r_bcnt;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_cv_nxt    = 1'b0;
    w_cdata_nxt = r_cdata;
    w_done_nxt  = 1'b0;
    w_go        = 1'b0;
    w_nx        = r_x + 16'd1;
    w_ny        = r_y;
    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        w_go        = enable;
      end
      S_CTRL: begin
        w_state_nxt = S_ACTIVE;
        w_x_nxt     = 16'd0;
        w_y_nxt     = 16'd0;
        w_valid_nxt = 1'b1;
        w_data_nxt  = f_pix(r_mode, 8'd0, 8'd0, r_fcnt);
      end
      S_ACTIVE: begin
        if (r_valid && source_ready) begin
          if (r_x == r_w - 16'd1) begin
            w_nx = 16'd0;
            w_ny = r_y + 16'd1;
          end
          if (r_x == r_w - 16'd1 && r_y == r_h - 16'd1) begin
            w_state_nxt = S_BLANK;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_fcnt_nxt  = r_fcnt + 8'd1;
            w_bcnt_nxt  = 16'd0;
          end else begin
            w_x_nxt    = w_nx;
            w_y_nxt    = w_ny;
            w_data_nxt = f_pix(r_mode, w_nx[7:0],
                               w_ny[7:0], r_fcnt);
          end
        end
      end
      default: begin
        w_bcnt_nxt = r_bcnt + 16'd1;
        if (r_bcnt == 16'(BLANK - 1)) begin
          w_state_nxt = S_IDLE;
          w_go        = enable;
        end
      end
    endcase
    // Frame boundary: relatch geometry/mode and emit the control packet.
    if (w_go) begin
      w_state_nxt = S_CTRL;
      w_w_nxt     = w_eff_w;
      w_h_nxt     = w_eff_h;
      w_mode_nxt  = pattern_sel;
      w_cv_nxt    = 1'b1;
      w_cdata_nxt = {w_eff_w, w_eff_h, 4'h0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= 16'd0;
      r_y     <= 16'd0;
      r_w     <= 16'(W);
      r_h     <= 16'(H);
      r_mode  <= 2'd0;
      r_fcnt  <= 8'd0;
      r_bcnt  <= 16'd0;
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_cv    <= 1'b0;
      r_cdata <= {16'(W), 16'(H), 4'h0};
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_w     <= w_w_nxt;
      r_h     <= w_h_nxt;
      r_mode  <= w_mode_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_cv    <= w_cv_nxt;
      r_cdata <= w_cdata_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign source_data       = r_data;
  assign source_valid      = r_valid;
  assign control_out_valid = r_cv;
  assign control_out_data  = r_cdata;
  assign frame_done        = r_done;

endmodule

// File: tb/tb_bayer_pattern_gen.sv
// Self-checking bench for bayer_pattern_gen against a coordinate-based
// pixel model; frame table, random frames, held enable and mid-frame reset.
module tb_bayer_pattern_gen;

  localparam int TB_W     = 8;
  localparam int TB_H     = 4;
  localparam int TB_BLANK = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] cfg_width;
  logic [15:0] cfg_height;
  logic [7:0]  source_data;
  logic        source_valid;
  logic        source_ready;
  logic [35:0] control_out_data;
  logic        control_out_valid;
  logic        frame_done;

  int tests = 0;
  int fails = 0;
  int model_fc = 0;

  bayer_pattern_gen #(
    .W(TB_W), .H(TB_H), .BLANK(TB_BLANK)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .enable           (enable),
    .pattern_sel      (pattern_sel),
    .cfg_width        (cfg_width),
    .cfg_height       (cfg_height),
    .source_data      (source_data),
    .source_valid     (source_valid),
    .source_ready     (source_ready),
    .control_out_data (control_out_data),
    .control_out_valid(control_out_valid),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cw;
    logic [15:0] ch;
    logic [1:0]  md;
    bit          rnd;
    logic [35:0] xc;
    int          xb;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference pixel: Bayer BGGR colour chosen by row/column parity.
  function automatic logic [7:0] exp_pix(input int md, input int x,
                                         input int y, input int fc);
    int c;
    int flat [4];
    flat = '{64, 128, 128, 192};
    c = (y % 2) * 2 + (x % 2);
    case (md)
      0:       return 8'(flat[c]);
      1:       return 8'(x % 256);
      2:       return 8'(y % 256);
      default: return 8'((x + y + fc) % 256);
    endcase
  endfunction

  task automatic run_frame(input logic [15:0] cw, input logic [15:0] ch,
                           input logic [1:0] md, input bit rnd,
                           input logic [35:0] xc, input int xb,
                           input string nm);
    int ew, eh, x, y, n, cyc, budget, bad, stall_bad, extra;
    logic [7:0] pd;
    logic pv, pr;
    ew = (cw == 0) ? TB_W : int'(cw);
    eh = (ch == 0) ? TB_H : int'(ch);
    budget = ew * eh * 30 + 50;
    @(negedge clk);
    cfg_width = cw; cfg_height = ch; pattern_sel = md;
    enable = 1'b1; source_ready = 1'b0;
    @(negedge clk);
    enable = 1'b0;
    cfg_width = 16'($urandom); cfg_height = 16'($urandom);
    pattern_sel = 2'($urandom);
    chk({nm, "_ctrl_valid"}, 64'(control_out_valid), 64'd1);
    chk({nm, "_ctrl_data"}, 64'(control_out_data), 64'(xc));
    chk({nm, "_ctrl_novalid"}, 64'(source_valid), 64'd0);
    x = 0; y = 0; n = 0; cyc = 0; bad = 0; stall_bad = 0;
    pv = 1'b0; pr = 1'b1; pd = 8'd0;
    while (n < ew * eh && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (pv && !pr && (source_valid !== 1'b1 || source_data !== pd))
        stall_bad++;
      source_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (source_valid) begin
        if (source_data !== exp_pix(md, x, y, model_fc)) begin
          if (bad == 0)
            $display("FAIL %s_pix (%0d,%0d): got %0h expected %0h",
                     nm, x, y, source_data, exp_pix(md, x, y, model_fc));
          bad++;
        end
        if (source_ready) begin
          n++;
          x++;
          if (x == ew) begin x = 0; y++; end
        end
      end
      pv = source_valid; pd = source_data; pr = source_ready;
    end
    chk({nm, "_timeout"}, 64'(cyc >= budget), 64'd0);
    chk({nm, "_pixels"}, 64'(bad), 64'd0);
    chk({nm, "_stall_hold"}, 64'(stall_bad), 64'd0);
    chk({nm, "_beats"}, 64'(n), 64'(xb));
    if (!rnd) chk({nm, "_full_rate"}, 64'(cyc), 64'(ew * eh));
    @(negedge clk);
    source_ready = 1'b1;
    chk({nm, "_done"}, 64'(frame_done), 64'd1);
    chk({nm, "_post_valid"}, 64'(source_valid), 64'd0);
    model_fc = (model_fc + 1) % 256;
    @(negedge clk);
    chk({nm, "_done_pulse"}, 64'(frame_done), 64'd0);
    extra = 0;
    repeat (TB_BLANK + 2) begin
      @(negedge clk);
      if (control_out_valid || source_valid) extra++;
    end
    chk({nm, "_idle_after"}, 64'(extra), 64'd0);
  endtask

  initial begin
    int t[$];
    int nd, cyc, n, xtra;
    bit dropped;
    logic [15:0] rw, rh;
    logic [1:0] rm;
    bit rr;

    tbl[0] = '{16'd4,   16'd2, 2'd0, 1'b0, 36'h000400020, 8};
    tbl[1] = '{16'd0,   16'd0, 2'd0, 1'b0, {16'd8, 16'd4, 4'h0}, 32};
    tbl[2] = '{16'd300, 16'd1, 2'd1, 1'b0, {16'd300, 16'd1, 4'h0}, 300};
    tbl[3] = '{16'd16,  16'd4, 2'd3, 1'b1, {16'd16, 16'd4, 4'h0}, 64};
    tbl[4] = '{16'd16,  16'd4, 2'd3, 1'b1, {16'd16, 16'd4, 4'h0}, 64};
    tbl[5] = '{16'd1,   16'd1, 2'd2, 1'b0, {16'd1, 16'd1, 4'h0}, 1};

    rst = 1'b1; enable = 1'b0; pattern_sel = 2'd0;
    cfg_width = 16'd0; cfg_height = 16'd0; source_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(source_valid), 64'd0);
    chk("rst_data", 64'(source_data), 64'd0);
    chk("rst_cvalid", 64'(control_out_valid), 64'd0);
    chk("rst_cdata", 64'(control_out_data), 64'({16'd8, 16'd4, 4'h0}));
    chk("rst_done", 64'(frame_done), 64'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_ctrl", 64'(control_out_valid), 64'd0);

    for (int i = 0; i < 6; i++)
      run_frame(tbl[i].cw, tbl[i].ch, tbl[i].md, tbl[i].rnd,
                tbl[i].xc, tbl[i].xb, $sformatf("tbl%0d", i));

    for (int i = 0; i < 4; i++) begin
      rw = 16'($urandom_range(1, 20));
      rh = 16'($urandom_range(1, 5));
      rm = 2'($urandom_range(0, 3));
      rr = 1'($urandom_range(0, 1));
      run_frame(rw, rh, rm, rr, {rw, rh, 4'h0}, int'(rw) * int'(rh),
                $sformatf("rnd%0d", i));
    end

    // Held enable: back-to-back 2x2 frames, then drop enable mid-frame.
    @(negedge clk);
    cfg_width = 16'd2; cfg_height = 16'd2; pattern_sel = 2'd0;
    source_ready = 1'b1; enable = 1'b1;
    nd = 0; cyc = 0; dropped = 1'b0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (control_out_valid) t.push_back(cyc);
      if (frame_done) nd++;
      if (!dropped && t.size() == 3 && cyc == t[2] + 2) begin
        enable = 1'b0;
        dropped = 1'b1;
      end
      if (dropped && cyc > t[2] + 5 + TB_BLANK + 20) break;
    end
    chk("hold_pkts", 64'(t.size()), 64'd3);
    chk("hold_gap1", 64'(t.size() >= 2 ? t[1] - t[0] : -1),
        64'(5 + TB_BLANK));
    chk("hold_gap2", 64'(t.size() >= 3 ? t[2] - t[1] : -1),
        64'(5 + TB_BLANK));
    chk("hold_frames", 64'(nd), 64'd3);
    model_fc = (model_fc + 3) % 256;

    // Reset while pixel 5 of a 4x4 frame is presented.
    @(negedge clk);
    cfg_width = 16'd4; cfg_height = 16'd4; pattern_sel = 2'd3;
    enable = 1'b1; source_ready = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    n = 0; cyc = 0;
    while (n < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (source_valid && source_ready) n++;
    end
    @(negedge clk);
    chk("rst_mid_pix5", 64'(source_data), 64'(exp_pix(3, 1, 1, model_fc)));
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(source_valid), 64'd0);
    chk("rst_mid_cvalid", 64'(control_out_valid), 64'd0);
    chk("rst_mid_cdata", 64'(control_out_data), 64'({16'd8, 16'd4, 4'h0}));
    xtra = 0;
    repeat (3) begin
      @(negedge clk);
      if (frame_done || source_valid) xtra++;
    end
    chk("rst_mid_quiet", 64'(xtra), 64'd0);
    rst = 1'b0;
    model_fc = 0;
    run_frame(16'd4, 16'd4, 2'd3, 1'b0, {16'd4, 16'd4, 4'h0}, 16,
              "rst_restart");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
